// File: rtl/mbist_checkerboard.sv
// Checkerboard BIST for a 16x2 SRAM: write P, read P, write ~P, read ~P.
// Read data is checked by a 2-stage pipeline aligned to the SRAM's registered output.
module mbist_checkerboard #(
  parameter bit INVERT_PLANE  = 1'b1,
  parameter bit ABORT_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] mem_address,
  output logic       mem_we_n,
  output logic       mem_cs_n,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] fail_addr,
  output logic [5:0] fail_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_W_P   = 3'd1;
  localparam logic [2:0] ST_R_P   = 3'd2;
  localparam logic [2:0] ST_W_N   = 3'd3;
  localparam logic [2:0] ST_R_N   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [3:0] LAST_ADDR  = 4'd15;
  localparam logic [3:0] LAST_DRAIN = 4'd1;

  typedef struct packed {
    logic [3:0] addr;
    logic [1:0] expected;
  } cmp_entry_t;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [3:0]  addr;
  logic [3:0]  addr_nxt;
  logic        write_nxt;
  logic        read_nxt;
  logic        access_nxt;
  logic [1:0]  wdata_nxt;
  logic [1:0]  expected_nxt;
  logic        start_ok;
  logic        mismatch;
  logic        abort;
  logic        pipe_v1;
  logic        pipe_v2;
  cmp_entry_t  pipe_d1;
  cmp_entry_t  pipe_d2;

  function automatic logic [1:0] pattern_p(input logic [3:0] a);
    logic b0;
    b0 = a[2] ^ a[0];
    return {b0 ^ INVERT_PLANE, b0};
  endfunction

  assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign mismatch = pipe_v2 && (mem_rdata != pipe_d2.expected);
  assign abort    = ABORT_ON_FAIL && mismatch;

  // The address counter doubles as the DRAIN cycle counter.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_W_P;
          addr_nxt  = '0;
        end
      end
      ST_W_P: begin
        addr_nxt = addr + 4'd1;
        if (addr == LAST_ADDR) state_nxt = ST_R_P;
      end
      ST_R_P: begin
        addr_nxt = addr + 4'd1;
        if (addr == LAST_ADDR) state_nxt = ST_W_N;
      end
      ST_W_N: begin
        addr_nxt = addr + 4'd1;
        if (addr == LAST_ADDR) state_nxt = ST_R_N;
      end
      ST_R_N: begin
        addr_nxt = addr + 4'd1;
        if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (addr == LAST_DRAIN) begin
          state_nxt = ST_DONE;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
      end
    endcase
    if (abort) begin
      state_nxt = ST_DONE;
      addr_nxt  = '0;
    end
  end

  // Memory command for the cycle being entered, decoded from the next state.
  always_comb begin
    write_nxt    = (state_nxt == ST_W_P) || (state_nxt == ST_W_N);
    read_nxt     = (state_nxt == ST_R_P) || (state_nxt == ST_R_N);
    access_nxt   = write_nxt || read_nxt;
    wdata_nxt    = '0;
    if (state_nxt == ST_W_P) begin
      wdata_nxt = pattern_p(addr_nxt);
    end else if (state_nxt == ST_W_N) begin
      wdata_nxt = ~pattern_p(addr_nxt);
    end
    expected_nxt = (state_nxt == ST_R_N) ? ~pattern_p(addr_nxt) : pattern_p(addr_nxt);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr        <= '0;
      mem_cs_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_address <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      mem_cs_n    <= ~access_nxt;
      mem_we_n    <= ~write_nxt;
      mem_address <= access_nxt ? addr_nxt : 4'd0;
      mem_wdata   <= wdata_nxt;
      busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done        <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v1 <= 1'b0;
      pipe_v2 <= 1'b0;
    end else if (abort) begin
      pipe_v1 <= 1'b0;
      pipe_v2 <= 1'b0;
    end else begin
      pipe_v1 <= read_nxt;
      pipe_v2 <= pipe_v1;
    end
  end

  // NOTE: payload flops carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    pipe_d1.addr     <= addr_nxt;
    pipe_d1.expected <= expected_nxt;
    pipe_d2          <= pipe_d1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      fail       <= 1'b1;
      fail_count <= fail_count + 6'd1;
      if (!fail) fail_addr <= pipe_d2.addr;
    end
  end

endmodule
